// File: rtl/lsu_ctrl.sv
// Load/store control between execute and dmem: one op at a time,
// single-cycle dmem request, bounded retry on refusal, one-cycle response.
// Ports: clk, reset_i (async, active-high);
//   execute side  ex_valid_i, ex_store_i, ex_addr_i, ex_data_i, ex_ready_o;
//   response      resp_valid_o, resp_load_o, resp_err_o, resp_data_o;
//   dmem side     mem_req_o, mem_we_o, mem_addr_o, mem_din_o,
//                 mem_dout_i, mem_refused_i.
module lsu_ctrl #(
  parameter int D_WIDTH   = 16,
  parameter int A_WIDTH   = 8,
  parameter int MAX_RETRY = 15,
  parameter int RETRY_W   = 4
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               ex_valid_i,
  input  logic               ex_store_i,
  input  logic [A_WIDTH-1:0] ex_addr_i,
  input  logic [D_WIDTH-1:0] ex_data_i,
  output logic               ex_ready_o,
  output logic               resp_valid_o,
  output logic               resp_load_o,
  output logic               resp_err_o,
  output logic [D_WIDTH-1:0] resp_data_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0] mem_din_o,
  input  logic [D_WIDTH-1:0] mem_dout_i,
  input  logic               mem_refused_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CHECK
  } state_e;

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [RETRY_W-1:0]   cnt_q, cnt_d;
  logic                 store_q, store_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [D_WIDTH-1:0]   din_q, din_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rload_q, rload_d;
  logic                 rerr_q, rerr_d;
  logic [D_WIDTH-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      store_q  <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rvalid_q <= 1'b0;
      rload_q  <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rvalid_q <= rvalid_d;
      rload_q  <= rload_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    // completion flags are single-cycle pulses
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rload_d  = rload_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          store_d = ex_store_i;
          addr_d  = ex_addr_i;
          din_d   = ex_store_i ? ex_data_i : '0;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = ex_store_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        if (!mem_refused_i) begin
          rvalid_d = 1'b1;
          rload_d  = ~store_q;
          if (!store_q) rdata_d = mem_dout_i;
          state_d  = IDLE;
        end else if (cnt_q < MAX_R) begin
          cnt_d   = cnt_q + RETRY_W'(1);
          req_d   = 1'b1;
          we_d    = store_q;
          state_d = ISSUE;
        end else begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rload_d  = ~store_q;
          rdata_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ex_ready_o   = (state_q == IDLE) & ~reset_i;
  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_din_o    = din_q;
  assign resp_valid_o = rvalid_q;
  assign resp_load_o  = rload_q;
  assign resp_err_o   = rerr_q;
  assign resp_data_o  = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a small dmem model.
// Stimulus pushes expected requests/responses; negedge monitors compare.
module tb_lsu_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MR = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          ex_valid_i;
  logic          ex_store_i;
  logic [AW-1:0] ex_addr_i;
  logic [DW-1:0] ex_data_i;
  logic          ex_ready_o;
  logic          resp_valid_o;
  logic          resp_load_o;
  logic          resp_err_o;
  logic [DW-1:0] resp_data_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o;
  logic [DW-1:0] mem_dout_i;
  logic          mem_refused_i;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .D_WIDTH(DW),
    .A_WIDTH(AW),
    .MAX_RETRY(MR),
    .RETRY_W(RW)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .ex_valid_i(ex_valid_i),
    .ex_store_i(ex_store_i),
    .ex_addr_i(ex_addr_i),
    .ex_data_i(ex_data_i),
    .ex_ready_o(ex_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_load_o(resp_load_o),
    .resp_err_o(resp_err_o),
    .resp_data_o(resp_data_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o),
    .mem_dout_i(mem_dout_i),
    .mem_refused_i(mem_refused_i)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } req_t;

  typedef struct packed {
    logic          load;
    logic          err;
    logic          chkd;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } resp_t;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    ref_q[$];
  req_t  req_q[$];
  resp_t resp_q[$];
  int    req_cyc[$];
  logic [DW-1:0] mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // dmem model + request monitor: answer is valid during CHECK
  always @(negedge clk) begin
    req_t e;
    bit   r;
    if (mem_req_o) begin
      req_cyc.push_back(cyc);
      if (req_q.size() == 0) begin
        chk("req_unexpected", {31'b0, mem_req_o}, 32'd0);
      end else begin
        e = req_q.pop_front();
        chk("req_we", {31'b0, mem_we_o}, {31'b0, e.we});
        chk("req_addr", {24'b0, mem_addr_o}, {24'b0, e.addr});
        chk("req_din", {16'b0, mem_din_o}, {16'b0, e.din});
      end
      r = (ref_q.size() != 0) ? ref_q.pop_front() : 1'b0;
      mem_refused_i = r;
      if (!mem_we_o) mem_dout_i = mem[mem_addr_o];
      else if (!r) mem[mem_addr_o] = mem_din_o;
    end
  end

  // response monitor
  always @(negedge clk) begin
    resp_t e;
    if (resp_valid_o) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", {31'b0, resp_valid_o}, 32'd0);
      end else begin
        e = resp_q.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_load", {31'b0, resp_load_o}, {31'b0, e.load});
        chk("resp_err", {31'b0, resp_err_o}, {31'b0, e.err});
        if (e.chkd)
          chk("resp_data", {16'b0, resp_data_o}, {16'b0, e.data});
      end
    end
  end

  task automatic do_op(bit st, logic [AW-1:0] a, logic [DW-1:0] d,
                       int natt, logic [3:0] refm, bit err,
                       logic [DW-1:0] rdata, bit chkd);
    int    c0;
    int    w;
    int    lowc;
    resp_t rs;
    req_t  rq;
    for (int i = 0; i < natt; i++) begin
      ref_q.push_back(refm[i]);
      rq.we   = st;
      rq.addr = a;
      rq.din  = st ? d : '0;
      req_q.push_back(rq);
    end
    req_cyc.delete();
    w = 0;
    while (!ex_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", {31'b0, ex_ready_o}, 32'd1);
    ex_valid_i = 1'b1;
    ex_store_i = st;
    ex_addr_i  = a;
    ex_data_i  = d;
    @(posedge clk);
    #1;
    c0 = cyc;
    ex_valid_i = 1'b0;
    ex_addr_i  = 8'hFF;
    ex_data_i  = 16'hDEAD;
    rs.load = ~st;
    rs.err  = err;
    rs.chkd = chkd;
    rs.data = rdata;
    rs.cyc  = c0 + 2 * natt;
    resp_q.push_back(rs);
    lowc = 0;
    @(negedge clk);
    while (!ex_ready_o && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    chk("ready_low_cycles", lowc, 2 * natt);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    reset_i       = 1'b1;
    ex_valid_i    = 1'b0;
    ex_store_i    = 1'b0;
    ex_addr_i     = '0;
    ex_data_i     = '0;
    mem_dout_i    = '0;
    mem_refused_i = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, ex_ready_o}, 32'd0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_addr", {24'b0, mem_addr_o}, 32'd0);
    chk("rst_din", {16'b0, mem_din_o}, 32'd0);
    chk("rst_rvalid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_rload", {31'b0, resp_load_o}, 32'd0);
    chk("rst_rerr", {31'b0, resp_err_o}, 32'd0);
    chk("rst_rdata", {16'b0, resp_data_o}, 32'd0);
    reset_i = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, ex_ready_o}, 32'd1);
    @(negedge clk);
    chk("ready_idle", {31'b0, ex_ready_o}, 32'd1);
    chk("req_idle", {31'b0, mem_req_o}, 32'd0);

    // 2: store, 3: back-to-back load of same word
    do_op(1'b1, 8'h01, 16'h00AB, 1, 4'b0000, 1'b0, 16'h0000, 1'b0);
    do_op(1'b0, 8'h01, 16'h5555, 1, 4'b0000, 1'b0, 16'h00AB, 1'b1);
    @(negedge clk);
    chk("hold_rvalid", {31'b0, resp_valid_o}, 32'd0);
    chk("hold_rload", {31'b0, resp_load_o}, 32'd1);
    chk("hold_rdata", {16'b0, resp_data_o}, 32'h00AB);

    // 4: load refused twice then accepted
    do_op(1'b0, 8'h02, 16'h0000, 3, 4'b0011, 1'b0, 16'h0000, 1'b1);
    chk("retry_req_count", req_cyc.size(), 32'd3);
    if (req_cyc.size() == 3) begin
      chk("retry_gap0", req_cyc[1] - req_cyc[0], 32'd2);
      chk("retry_gap1", req_cyc[2] - req_cyc[1], 32'd2);
    end

    // 5: store always refused -> error after MR+1 attempts
    do_op(1'b1, 8'h10, 16'h1234, 4, 4'b1111, 1'b1, 16'h0000, 1'b1);
    chk("err_req_count", req_cyc.size(), 32'd4);
    @(negedge clk);
    chk("err_clear", {31'b0, resp_err_o}, 32'd0);
    chk("err_rvalid_clear", {31'b0, resp_valid_o}, 32'd0);
    chk("err_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("err_store_dropped", {16'b0, mem[8'h10]}, 32'd0);

    // 6: reset during CHECK of a refused load
    ref_q.push_back(1'b1);
    req_q.push_back('{1'b0, 8'h04, 16'h0000});
    ex_valid_i = 1'b1;
    ex_store_i = 1'b0;
    ex_addr_i  = 8'h04;
    ex_data_i  = 16'h0000;
    @(posedge clk);
    #1;
    ex_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, ex_ready_o}, 32'd0);
    chk("midrst_req", {31'b0, mem_req_o}, 32'd0);
    chk("midrst_addr", {24'b0, mem_addr_o}, 32'd0);
    chk("midrst_rvalid", {31'b0, resp_valid_o}, 32'd0);
    chk("midrst_rerr", {31'b0, resp_err_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("midrst_ready_after", {31'b0, ex_ready_o}, 32'd1);
    @(negedge clk);
    do_op(1'b1, 8'h03, 16'h0005, 1, 4'b0000, 1'b0, 16'h0000, 1'b0);
    do_op(1'b0, 8'h03, 16'h0000, 1, 4'b0000, 1'b0, 16'h0005, 1'b1);

    repeat (4) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("ref_q_drained", ref_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control unit directly upstream of dmem; sits between the execute stage and data memory.
- Accepts one load or store at a time from execute over a valid/ready handshake and issues it to dmem as a single-cycle request.
- Retries requests that dmem refuses, up to a bounded count.
- Returns a one-cycle completion pulse, with load data when the op is a load, or an error flag when retries are exhausted.

Parameters:
D_WIDTH, 16, data word width; matches dmem.
A_WIDTH, 8, address width; matches dmem.
MAX_RETRY, 15, number of retries after the first refused attempt before the op is abandoned with error.
RETRY_W, 4, width of the retry counter; must satisfy MAX_RETRY < 2^RETRY_W.

Ports:
clk  in  1  system clock, rising-edge.
reset_i  in  1  asynchronous, active-high reset.
ex_valid_i  in  1  execute presents an op.
ex_store_i  in  1  1 = store, 0 = load; sampled with ex_valid_i.
ex_addr_i  in  A_WIDTH  memory address.
ex_data_i  in  D_WIDTH  store data; ignored for loads.
ex_ready_o  out  1  unit can accept an op this cycle; doubles as the inverse pipeline stall.
resp_valid_o  out  1  one-cycle completion pulse.
resp_load_o  out  1  completed op was a load.
resp_err_o  out  1  op abandoned after MAX_RETRY retries.
resp_data_o  out  D_WIDTH  load data; valid when resp_valid_o & resp_load_o & ~resp_err_o.
mem_req_o  out  1  drives dmem read_write_req_i.
mem_we_o  out  1  drives dmem write_en_i.
mem_addr_o  out  A_WIDTH  drives dmem addr_i.
mem_din_o  out  D_WIDTH  drives dmem din_i.
mem_dout_i  in  D_WIDTH  from dmem dout_o.
mem_refused_i  in  1  from dmem refused_o.

Behaviour:
- dmem contract:
  - dmem samples the request on the rising edge that ends the request cycle.
  - mem_refused_i and mem_dout_i are valid during the following cycle.
- States are IDLE, ISSUE and CHECK. All outputs except ex_ready_o are registered.
- ex_ready_o = (state == IDLE) & ~reset_i.
- Reset:
  - Asynchronously forces state to IDLE and the retry counter to 0.
  - All registered outputs go to 0: mem_req_o, mem_we_o, mem_addr_o, mem_din_o, resp_valid_o, resp_load_o, resp_err_o, resp_data_o.
  - ex_ready_o is 0 while reset_i is high.
- IDLE:
  - On ex_valid_i at a rising edge, latch store/addr/data, clear the retry counter and go to ISSUE.
  - Also on that edge, set mem_req_o = 1, mem_we_o = ex_store_i, mem_addr_o = ex_addr_i, mem_din_o = ex_data_i (or 0 for loads).
- ISSUE:
  - mem_req_o is high for exactly this one cycle.
  - Next edge: clear mem_req_o and mem_we_o, go to CHECK.
  - mem_addr_o and mem_din_o hold their latched values.
- CHECK, mem_refused_i = 0:
  - Register resp_valid_o = 1, resp_load_o = latched op, resp_err_o = 0, go to IDLE.
  - resp_data_o = mem_dout_i for a load; unchanged for a store.
- CHECK, mem_refused_i = 1 and retry count < MAX_RETRY:
  - Increment the counter, reassert mem_req_o/mem_we_o with the same latched values, go to ISSUE.
  - Each retry costs 2 cycles.
- CHECK, mem_refused_i = 1 and retry count == MAX_RETRY:
  - resp_valid_o = 1, resp_err_o = 1, resp_load_o = latched op, resp_data_o = 0, go to IDLE.
- resp_valid_o, resp_err_o:
  - Clear on the edge after they are set.
  - resp_load_o and resp_data_o hold their values until the next completion.
- Latency, no refusal:
  - Accept at edge E0; mem_req_o is high E0–E1; CHECK is E1–E2; resp_valid_o is high E2–E3.
  - ex_ready_o is high again from E2, so a back-to-back accept at E3 is legal. Minimum 3 cycles per op.
- ex_valid_i and ex_* inputs are ignored outside IDLE. Execute must hold them until ex_ready_o is seen.
- The address is passed unmodified; there is no alignment or bounds check.
- Total attempts per op = MAX_RETRY + 1. The counter never wraps.
- Reset mid-op (ISSUE or CHECK): the op is dropped with no response, and mem_req_o falls immediately. A refused_o arriving after reset is ignored.

Test Plan:
1. Hold reset_i = 1 for 2 cycles, then release -> all outputs 0 during reset; ex_ready_o = 1 on the first cycle after release; mem_req_o stays 0.
2. Store addr 0x01, data 0x00AB, refused = 0 -> mem_req_o = 1 for exactly one cycle with we = 1, addr 0x01, din 0x00AB; resp_valid_o pulses 2 cycles after accept with load = 0, err = 0.
3. Load addr 0x01, with mem_dout_i = 0x00AB in the CHECK cycle -> mem_req_o pulse with we = 0, addr 0x01; resp_valid_o = 1, resp_load_o = 1, resp_data_o = 0x00AB, held after the pulse.
4. Load addr 0x02, refused = 1 on the first two attempts, 0 on the third -> three mem_req_o pulses spaced 2 cycles apart, all addr 0x02; a single resp_valid_o; ex_ready_o low throughout (6 cycles).
5. MAX_RETRY = 3, store with refused always 1 -> exactly 4 mem_req_o pulses, then resp_valid_o = 1, resp_err_o = 1, resp_data_o = 0; ex_ready_o returns high.
6. Assert reset_i during CHECK of a load -> mem_req_o and resp outputs go to 0 immediately; no resp_valid_o; a following store to addr 0x03, data 0x0005 completes normally.
